// File: rtl/cmp_arb_pkg.sv
// Shared types and constants for the comparator arbiter: FSM state encoding,
// requester-count limits, and the packed response record.
package cmp_arb_pkg;

    localparam int NREQ_MAX = 8;
    localparam int ID_W     = 3;
    localparam int OP_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            less;
        logic            equal;
    } rsp_t;

    // Increment a requester index, wrapping at n (n need not be a power of two).
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx, input int n);
        logic [ID_W-1:0] r;
        if (int'(idx) >= n - 1) r = '0;
        else                    r = idx + 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/cmp_arbiter_brcomp.sv
// Unsigned magnitude comparator: A < B from the borrow of a 9-bit A-B,
// equality from a zero difference. less and equal are mutually exclusive.
module brcomp
    import cmp_arb_pkg::*;
(
    input  logic [OP_W-1:0] a_i,
    input  logic [OP_W-1:0] b_i,
    output logic            less_o,
    output logic            equal_o
);

    logic [OP_W:0] w_diff;

    assign w_diff  = {1'b0, a_i} - {1'b0, b_i};
    assign less_o  = w_diff[OP_W];
    assign equal_o = ~w_diff[OP_W] & (w_diff[OP_W-1:0] == '0);

endmodule

// File: rtl/cmp_arbiter.sv
// NREQ requesters share one brcomp through an IDLE/CMP/RESP FSM.
// Define CMP_ARB_RR_EN for round-robin selection; default is fixed priority (lowest index).
module cmp_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*OP_W-1:0] req_a_i,
    input  logic [NREQ*OP_W-1:0] req_b_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic                 rsp_less_o,
    output logic                 rsp_equal_o
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_any;
    logic [ID_W-1:0] w_gnt_idx;
    logic            w_accept;
    logic [OP_W-1:0] w_sel_a;
    logic [OP_W-1:0] w_sel_b;
    logic [OP_W-1:0] r_op_a;
    logic [OP_W-1:0] r_op_b;
    logic [ID_W-1:0] r_op_id;
    logic            w_less;
    logic            w_equal;
    rsp_t            r_rsp;

    // ---------------- requester selection ----------------
`ifdef CMP_ARB_RR_EN
    logic [ID_W-1:0] r_ptr;

    // Walk offsets from high to low so the requester closest to the pointer wins.
    always_comb begin
        int j;
        j         = 0;
        w_any     = 1'b0;
        w_gnt_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(r_ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (req_valid_i[j]) begin
                w_any     = 1'b1;
                w_gnt_idx = ID_W'(j);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       r_ptr <= '0;
        else if (w_accept) r_ptr <= wrap_inc(w_gnt_idx, NREQ);
    end
`else
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                w_any     = 1'b1;
                w_gnt_idx = ID_W'(i);
            end
        end
    end
`endif

    assign w_accept = (r_state == ST_IDLE) && w_any;

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == ID_W'(i)) begin
                w_sel_a = req_a_i[i*OP_W +: OP_W];
                w_sel_b = req_b_i[i*OP_W +: OP_W];
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any)       w_state_nxt = ST_CMP;
            ST_CMP:                   w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready_i) w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    // rst_ni gates ready so a held request cannot see a grant while reset is low.
    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                for (int i = 0; i < NREQ; i++)
                    req_ready_o[i] = rst_ni && w_any && (w_gnt_idx == ID_W'(i));
            end
            ST_RESP: rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    // Operands are captured at accept so later requester changes cannot leak in.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_op_id <= '0;
        end else if (w_accept) begin
            r_op_a  <= w_sel_a;
            r_op_b  <= w_sel_b;
            r_op_id <= w_gnt_idx;
        end
    end

    brcomp u_brcomp (
        .a_i     (r_op_a),
        .b_i     (r_op_b),
        .less_o  (w_less),
        .equal_o (w_equal)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp <= '0;
        end else if (r_state == ST_CMP) begin
            r_rsp.id    <= r_op_id;
            r_rsp.less  <= w_less;
            r_rsp.equal <= w_equal;
        end
    end

    assign rsp_id_o    = r_rsp.id;
    assign rsp_less_o  = r_rsp.less;
    assign rsp_equal_o = r_rsp.equal;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: vector table plus hand-written corner sequences,
// with a scoreboard fed at each observed grant and drained at each response handshake.
module tb_cmp_arbiter;
    import cmp_arb_pkg::*;

    localparam int NREQ = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [NREQ-1:0]      req_valid_i;
    logic [NREQ*8-1:0]    req_a_i;
    logic [NREQ*8-1:0]    req_b_i;
    logic [NREQ-1:0]      req_ready_o;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [2:0]           rsp_id_o;
    logic                 rsp_less_o;
    logic                 rsp_equal_o;

    cmp_arbiter #(.NREQ(NREQ)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_id_o    (rsp_id_o),
        .rsp_less_o  (rsp_less_o),
        .rsp_equal_o (rsp_equal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic       less;
        logic       equal;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];
    int   grants[$];
    rsp_t last_rsp;
    int   cyc = 0;
    int   last_acc = 0;
    logic prev_rsp_v = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b);
        req_a_i[k*8 +: 8] = a;
        req_b_i[k*8 +: 8] = b;
    endtask

    // Called at posedge+1; samples mid-cycle, then advances to the next posedge+1.
    task automatic tick();
        rsp_t e;
        #3;
        chk("ready_onehot", 32'($countones(req_ready_o) <= 1), 1);
        if (rsp_valid_o) chk("ready_in_resp", 32'(req_ready_o), 0);
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready_o[i]) begin
                chk("grant_valid", 32'(req_valid_i[i]), 1);
                grants.push_back(i);
                last_acc = cyc;
                e.id    = 3'(i);
                e.less  = req_a_i[i*8 +: 8] <  req_b_i[i*8 +: 8];
                e.equal = req_a_i[i*8 +: 8] == req_b_i[i*8 +: 8];
                exp_q.push_back(e);
            end
        end
        if (rsp_valid_o && !prev_rsp_v) chk("latency", 32'(cyc - last_acc), 2);
        prev_rsp_v = rsp_valid_o;
        if (rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid_o), 0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_id",    32'(rsp_id_o),    32'(e.id));
                chk("rsp_less",  32'(rsp_less_o),  32'(e.less));
                chk("rsp_equal", 32'(rsp_equal_o), 32'(e.equal));
                last_rsp.id    = rsp_id_o;
                last_rsp.less  = rsp_less_o;
                last_rsp.equal = rsp_equal_o;
            end
        end
        cyc++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) chk("rsp_timeout", 32'(exp_q.size()), 0);
    endtask

    task automatic wait_grant(input int cnt, input int budget);
        int n = 0;
        while (grants.size() < cnt && n < budget) begin
            tick();
            n++;
        end
        if (grants.size() < cnt) chk("grant_timeout", 32'(grants.size()), 32'(cnt));
    endtask

    // Called at posedge+1; leaves reset released at a later posedge+1.
    task automatic do_reset(input string tag);
        rst_ni = 1'b0;
        #1;
        chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 0);
        chk({tag, "_ready"},     32'(req_ready_o), 0);
        chk({tag, "_rsp_id"},    32'(rsp_id_o),    0);
        chk({tag, "_rsp_less"},  32'(rsp_less_o),  0);
        chk({tag, "_rsp_equal"}, 32'(rsp_equal_o), 0);
        exp_q.delete();
        prev_rsp_v = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        vec_t vecs[7];
        int   exp_order[5];
        int   g0;
        logic [2:0] cap_id;
        logic cap_less, cap_equal;

        vecs[0] = '{0, 8'h10, 8'h20, 1'b1, 1'b0};
        vecs[1] = '{1, 8'hFF, 8'hFF, 1'b0, 1'b1};
        vecs[2] = '{2, 8'h00, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{3, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{1, 8'h80, 8'h7F, 1'b0, 1'b0};
        vecs[5] = '{2, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[6] = '{3, 8'h7F, 8'h80, 1'b1, 1'b0};

        rst_ni      = 1'b0;
        req_valid_i = '0;
        req_a_i     = '0;
        req_b_i     = '0;
        rsp_ready_i = 1'b1;
        #2;
        chk("init_rsp_valid", 32'(rsp_valid_o), 0);
        chk("init_ready",     32'(req_ready_o), 0);
        chk("init_rsp_id",    32'(rsp_id_o),    0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Vector table: one requester at a time.
        foreach (vecs[v]) begin
            g0 = grants.size();
            set_req(vecs[v].id, vecs[v].a, vecs[v].b);
            req_valid_i[vecs[v].id] = 1'b1;
            wait_grant(g0 + 1, 10);
            req_valid_i = '0;
            wait_rsp(10);
            chk("vec_id",    32'(last_rsp.id),    32'(vecs[v].id));
            chk("vec_less",  32'(last_rsp.less),  32'(vecs[v].less));
            chk("vec_equal", 32'(last_rsp.equal), 32'(vecs[v].equal));
            chk("vec_not_both", 32'(last_rsp.less & last_rsp.equal), 0);
        end

        // Grant order with all requesters continuously active.
        do_reset("rst_a");
        for (int k = 0; k < NREQ; k++) set_req(k, 8'(k), 8'h02);
        grants.delete();
        req_valid_i = '1;
        wait_grant(5, 40);
        req_valid_i = '0;
        wait_rsp(20);
`ifdef CMP_ARB_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        for (int k = 0; k < 5; k++)
            chk("grant_order", 32'((k < grants.size()) ? grants[k] : -1), 32'(exp_order[k]));

        // Backpressure: hold RESP for 5 cycles with another requester pending.
        do_reset("rst_b");
        rsp_ready_i = 1'b0;
        set_req(2, 8'h30, 8'h30);
        set_req(0, 8'h01, 8'h09);
        g0 = grants.size();
        req_valid_i = 4'b0100;
        wait_grant(g0 + 1, 10);
        req_valid_i = 4'b0001;
        tick();
        chk("bp_valid", 32'(rsp_valid_o), 1);
        cap_id = rsp_id_o; cap_less = rsp_less_o; cap_equal = rsp_equal_o;
        chk("bp_id0", 32'(cap_id), 2);
        chk("bp_eq0", 32'(cap_equal), 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_valid", 32'(rsp_valid_o), 1);
            chk("bp_hold_ready", 32'(req_ready_o), 0);
            chk("bp_hold_id",    32'(rsp_id_o),    32'(cap_id));
            chk("bp_hold_less",  32'(rsp_less_o),  32'(cap_less));
            chk("bp_hold_equal", 32'(rsp_equal_o), 32'(cap_equal));
        end
        rsp_ready_i = 1'b1;
        g0 = grants.size();
        tick();
        chk("bp_released", 32'(rsp_valid_o), 0);
        wait_grant(g0 + 1, 5);
        chk("bp_next_grant", 32'(grants[grants.size()-1]), 0);
        req_valid_i = '0;
        wait_rsp(10);
        chk("bp_next_less", 32'(last_rsp.less), 1);

        // Reset while CMP with the request still pending.
        set_req(1, 8'h01, 8'h02);
        g0 = grants.size();
        req_valid_i = 4'b0010;
        wait_grant(g0 + 1, 10);
        set_req(1, 8'h40, 8'h20);
        do_reset("rst_cmp");
        chk("rst_no_stale", 32'(rsp_valid_o), 0);
        g0 = grants.size();
        wait_grant(g0 + 1, 5);
        req_valid_i = '0;
        wait_rsp(10);
        chk("rst_reacc_id",   32'(last_rsp.id),   1);
        chk("rst_reacc_less", 32'(last_rsp.less), 0);

        // Operand change after acceptance must not affect the result.
        set_req(0, 8'h05, 8'h10);
        g0 = grants.size();
        req_valid_i = 4'b0001;
        wait_grant(g0 + 1, 10);
        set_req(0, 8'h50, 8'h10);
        req_valid_i = '0;
        wait_rsp(10);
        chk("opchg_less",  32'(last_rsp.less),  1);
        chk("opchg_equal", 32'(last_rsp.equal), 0);

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
